// File: rtl/btpipe_out_buffer.sv
// Buffered source for a block-throttled 32-bit output pipe: wide user writes in, one word per read out.
// Define BTPO_STATS_EN to build the saturating drop/underrun counters; otherwise they read as 0.
module btpipe_out_buffer #(
  parameter int IN_LANES    = 1,
  parameter int DEPTH       = 512,
  parameter int BLOCK_WORDS = 256
) (
  input  logic                                   okClk,
  input  logic                                   reset,
  input  logic                                   wr_en,
  input  logic [32*IN_LANES-1:0]                 wr_data,
  output logic                                   full,
  input  logic                                   ep_read,
  input  logic                                   ep_blockstrobe,
  output logic [31:0]                            ep_datain,
  output logic                                   ep_ready,
  output logic [$clog2(DEPTH*IN_LANES+1)-1:0]    level,
  input  logic                                   clr_flags,
  output logic                                   overflow,
  output logic                                   underrun,
  output logic [15:0]                            drop_count,
  output logic [15:0]                            underrun_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int ENT_W  = $clog2(DEPTH + 1);
  localparam int LANE_W = (IN_LANES > 1) ? $clog2(IN_LANES) : 1;
  localparam int LVL_W  = $clog2(DEPTH * IN_LANES + 1);
  localparam int REM_W  = $clog2(BLOCK_WORDS + 1);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(IN_LANES - 1);
  localparam logic [ENT_W-1:0]  DEPTH_ENT = ENT_W'(DEPTH);
  localparam logic [LVL_W-1:0]  BW_LVL    = LVL_W'(BLOCK_WORDS);
  localparam logic [REM_W-1:0]  BW_REM    = REM_W'(BLOCK_WORDS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BLOCK = 1'b1
  } state_t;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [ENT_W-1:0]  entries_q, entries_d;
  logic              full_q, full_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [31:0]       ep_datain_q, ep_datain_d;
  logic              overflow_q, overflow_d;
  logic              underrun_q, underrun_d;

  state_t            state_q;
  logic [REM_W-1:0]  remaining_q;
  logic              ep_ready_q;

  logic              push, pop, rd_fire, level_zero;
  logic              drop_evt, und_evt;
  logic [31:0]       lane_word [IN_LANES];
  logic [31:0]       head_word;

  // One bank per lane so a whole user write lands in a single cycle.
  generate
    for (genvar gi = 0; gi < IN_LANES; gi++) begin : g_bank
      logic [31:0] mem [DEPTH];
      always_ff @(posedge okClk) begin
        if (push) begin
          mem[wr_ptr_q] <= wr_data[32*gi +: 32];
        end
      end
      assign lane_word[gi] = mem[rd_ptr_q];
    end
  endgenerate

  assign head_word  = lane_word[lane_q];
  assign level_zero = (level_q == '0);
  assign rd_fire    = ep_read && !level_zero;
  assign pop        = rd_fire && (lane_q == LAST_LANE);
  assign push       = wr_en && !full_q;
  assign drop_evt   = wr_en && full_q;
  assign und_evt    = ep_read && level_zero;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    lane_d      = lane_q;
    entries_d   = entries_q;
    ep_datain_d = ep_datain_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_fire) begin
      lane_d = pop ? '0 : lane_q + LANE_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   entries_d = entries_q + ENT_W'(1);
      2'b01:   entries_d = entries_q - ENT_W'(1);
      default: entries_d = entries_q;
    endcase
    if (ep_read) begin
      ep_datain_d = level_zero ? 32'h0 : head_word;
    end

    // A partially consumed head entry still occupies a slot.
    full_d  = (entries_d == DEPTH_ENT);
    level_d = LVL_W'(32'(entries_d) * 32'(IN_LANES) - 32'(lane_d));

    // An event coincident with a clear wins over the clear.
    overflow_d = (overflow_q && !clr_flags) || drop_evt;
    underrun_d = (underrun_q && !clr_flags) || und_evt;
  end

  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      lane_q      <= '0;
      entries_q   <= '0;
      full_q      <= 1'b0;
      level_q     <= '0;
      ep_datain_q <= '0;
      overflow_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      lane_q      <= lane_d;
      entries_q   <= entries_d;
      full_q      <= full_d;
      level_q     <= level_d;
      ep_datain_q <= ep_datain_d;
      overflow_q  <= overflow_d;
      underrun_q  <= underrun_d;
    end
  end

  // Block tracker: ready is withheld for the whole of a block once its strobe is seen.
  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      ep_ready_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ep_blockstrobe) begin
            state_q     <= ST_BLOCK;
            remaining_q <= BW_REM;
            ep_ready_q  <= 1'b0;
          end else begin
            ep_ready_q  <= (level_d >= BW_LVL);
          end
        end
        ST_BLOCK: begin
          ep_ready_q <= 1'b0;
          if (ep_blockstrobe) begin
            remaining_q <= BW_REM;
          end else if (ep_read) begin
            remaining_q <= remaining_q - REM_W'(1);
            if (remaining_q == REM_W'(1)) begin
              state_q    <= ST_IDLE;
              ep_ready_q <= (level_d >= BW_LVL);
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          ep_ready_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef BTPO_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] und_cnt_q, und_cnt_d;

  always_comb begin
    drop_cnt_d = clr_flags ? 16'h0 : drop_cnt_q;
    und_cnt_d  = clr_flags ? 16'h0 : und_cnt_q;
    if (drop_evt) begin
      drop_cnt_d = clr_flags ? 16'h1 :
                   (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'h1;
    end
    if (und_evt) begin
      und_cnt_d = clr_flags ? 16'h1 :
                  (und_cnt_q == 16'hFFFF) ? und_cnt_q : und_cnt_q + 16'h1;
    end
  end

  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
      und_cnt_q  <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      und_cnt_q  <= und_cnt_d;
    end
  end

  assign drop_count     = drop_cnt_q;
  assign underrun_count = und_cnt_q;
`else
  assign drop_count     = 16'h0;
  assign underrun_count = 16'h0;
`endif

  assign full      = full_q;
  assign level     = level_q;
  assign ep_datain = ep_datain_q;
  assign ep_ready  = ep_ready_q;
  assign overflow  = overflow_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_btpipe_out_buffer.sv
// Randomized and directed bench for btpipe_out_buffer against a word-queue reference model.
module tb_btpipe_out_buffer;

  localparam int L  = 2;
  localparam int D  = 4;
  localparam int BW = 4;
  localparam int LW = $clog2(D*L+1);

  logic          okClk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [32*L-1:0] wr_data = '0;
  logic          ep_read = 1'b0;
  logic          ep_blockstrobe = 1'b0;
  logic          clr_flags = 1'b0;
  logic          full;
  logic [31:0]   ep_datain;
  logic          ep_ready;
  logic [LW-1:0] level;
  logic          overflow;
  logic          underrun;
  logic [15:0]   drop_count;
  logic [15:0]   underrun_count;

  btpipe_out_buffer #(.IN_LANES(L), .DEPTH(D), .BLOCK_WORDS(BW)) u_dut (
    .okClk(okClk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .ep_read(ep_read), .ep_blockstrobe(ep_blockstrobe), .ep_datain(ep_datain),
    .ep_ready(ep_ready), .level(level), .clr_flags(clr_flags), .overflow(overflow),
    .underrun(underrun), .drop_count(drop_count), .underrun_count(underrun_count)
  );

  always #5 okClk = ~okClk;

  // Reference model: the FIFO is just a queue of 32-bit words in send order.
  logic [31:0] mq[$];
  logic [31:0] m_datain = '0;
  bit          m_ready = 0, m_inblk = 0, m_ovf = 0, m_und = 0;
  int          m_rem = 0, m_dcnt = 0, m_ucnt = 0;
  int          checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int m_entries();
    return (mq.size() + L - 1) / L;
  endfunction

  function automatic int bump(input int c, input bit ev, input bit cl);
    if (ev) return cl ? 1 : ((c < 65535) ? c + 1 : c);
    return cl ? 0 : c;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_datain = '0; m_ready = 0; m_inblk = 0; m_ovf = 0; m_und = 0;
    m_rem = 0; m_dcnt = 0; m_ucnt = 0;
  endtask

  task automatic model_step();
    int sz0, lvl;
    bit full0;
    if (reset) begin
      model_reset();
      return;
    end
    sz0   = mq.size();
    full0 = (m_entries() == D);
    if (ep_read) m_datain = (sz0 > 0) ? mq.pop_front() : 32'h0;
    if (wr_en && !full0)
      for (int k = 0; k < L; k++) mq.push_back(wr_data[32*k +: 32]);
    lvl    = mq.size();
    m_ovf  = (m_ovf && !clr_flags) || (wr_en && full0);
    m_und  = (m_und && !clr_flags) || (ep_read && sz0 == 0);
    m_dcnt = bump(m_dcnt, wr_en && full0, clr_flags);
    m_ucnt = bump(m_ucnt, ep_read && sz0 == 0, clr_flags);
    if (!m_inblk) begin
      if (ep_blockstrobe) begin
        m_inblk = 1; m_rem = BW; m_ready = 0;
      end else begin
        m_ready = (lvl >= BW);
      end
    end else begin
      m_ready = 0;
      if (ep_blockstrobe) m_rem = BW;
      else if (ep_read) begin
        m_rem--;
        if (m_rem == 0) begin
          m_inblk = 0;
          m_ready = (lvl >= BW);
        end
      end
    end
  endtask

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge okClk) begin
    chk("datain", ep_datain, m_datain);
    chk("ready", ep_ready, m_ready);
    chk("full", full, m_entries() == D);
    chk("level", level, mq.size());
    chk("overflow", overflow, m_ovf);
    chk("underrun", underrun, m_und);
`ifdef BTPO_STATS_EN
    chk("drop_count", drop_count, m_dcnt);
    chk("underrun_count", underrun_count, m_ucnt);
`else
    chk("drop_count", drop_count, 0);
    chk("underrun_count", underrun_count, 0);
`endif
  end

  task automatic cyc(input bit we, input logic [63:0] wd, input bit rd, input bit bs, input bit cl);
    wr_en = we; wr_data = wd; ep_read = rd; ep_blockstrobe = bs; clr_flags = cl;
    @(posedge okClk);
    #1 model_step();
    @(negedge okClk);
  endtask

  task automatic idle();
    cyc(0, '0, 0, 0, 0);
  endtask

  initial begin
    @(negedge okClk);
    idle();
    reset = 1'b0;
    idle();

    // Block of 4 words from two 2-lane writes
    cyc(1, {32'd2, 32'd1}, 0, 0, 0);
    chk("t1_ready_early", ep_ready, 0);
    cyc(1, {32'd4, 32'd3}, 0, 0, 0);
    chk("t1_ready", ep_ready, 1);
    cyc(0, '0, 0, 1, 0);
    chk("t1_ready_strobe", ep_ready, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, '0, 1, 0, 0);
      chk("t1_data", ep_datain, k);
      chk("t1_ready_blk", ep_ready, 0);
    end
    idle();

    // Fill to full, one dropped write, then drain
    for (int k = 0; k < 5; k++) begin
      cyc(1, {32'h100 + 32'(2*k+1), 32'h100 + 32'(2*k)}, 0, 0, 0);
      if (k == 3) chk("t2_full", full, 1);
    end
    chk("t2_overflow", overflow, 1);
    chk("t2_level", level, 8);
`ifdef BTPO_STATS_EN
    chk("t2_drop_count", drop_count, 1);
`endif
    cyc(0, '0, 1, 0, 0);
    chk("t2_first_word", ep_datain, 32'h100);
    chk("t2_full_partial", full, 1);
    cyc(0, '0, 1, 0, 0);
    chk("t2_full_freed", full, 0);
    for (int k = 0; k < 6; k++) cyc(0, '0, 1, 0, 0);
    chk("t2_last_word", ep_datain, 32'h107);

    // Empty reads, clear, and clear coinciding with an event
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 1, 0, 0);
    chk("t3_datain", ep_datain, 0);
    chk("t3_underrun", underrun, 1);
    chk("t3_level", level, 0);
`ifdef BTPO_STATS_EN
    chk("t3_ucount", underrun_count, 2);
`endif
    cyc(0, '0, 0, 0, 1);
    chk("t3_clr_underrun", underrun, 0);
    chk("t3_clr_overflow", overflow, 0);
    chk("t3_clr_ucount", underrun_count, 0);
    cyc(0, '0, 1, 0, 1);
    chk("t3_clr_event_wins", underrun, 1);
`ifdef BTPO_STATS_EN
    chk("t3_clr_event_cnt", underrun_count, 1);
`endif
    cyc(0, '0, 0, 0, 1);

    // Steady level 3 with simultaneous write/read, wrapping pointers twice
    cyc(1, {32'h201, 32'h200}, 0, 0, 0);
    cyc(1, {32'h203, 32'h202}, 0, 0, 0);
    cyc(0, '0, 1, 0, 0);
    chk("t4_level3", level, 3);
    for (int j = 0; j < 16; j++) begin
      cyc(j % 2 == 0, {32'h300 + 32'(2*j+1), 32'h300 + 32'(2*j)}, 1, 0, 0);
      if (j % 2 == 1) chk("t4_level_steady", level, 3);
    end
    for (int k = 0; k < 3; k++) cyc(0, '0, 1, 0, 0);
    chk("t4_drained", level, 0);

    // Reset in the middle of a block
    cyc(1, {32'h402, 32'h401}, 0, 0, 0);
    cyc(1, {32'h404, 32'h403}, 0, 0, 0);
    cyc(0, '0, 0, 1, 0);
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 1, 0, 0);
    chk("t5_pre_reset_data", ep_datain, 32'h402);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("t5_rst_datain", ep_datain, 0);
    chk("t5_rst_level", level, 0);
    chk("t5_rst_ready", ep_ready, 0);
    chk("t5_rst_full", full, 0);
    @(negedge okClk);
    idle();
    reset = 1'b0;
    cyc(1, {32'h502, 32'h501}, 0, 0, 0);
    chk("t5_ready_low", ep_ready, 0);
    cyc(1, {32'h504, 32'h503}, 0, 0, 0);
    chk("t5_ready_idle", ep_ready, 1);
    for (int k = 0; k < 4; k++) cyc(0, '0, 1, 0, 0);

    // Randomized traffic: write-heavy then read-heavy
    for (int i = 0; i < 600; i++) begin
      bit we, rd, bs, cl;
      we = ($urandom_range(0, 99) < ((i < 300) ? 65 : 35));
      rd = ($urandom_range(0, 99) < ((i < 300) ? 35 : 65));
      bs = ($urandom_range(0, 15) == 0);
      cl = ($urandom_range(0, 31) == 0);
      cyc(we, {$urandom, $urandom}, rd, bs, cl);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
